// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: opcodes, data/address types, FSM state, latched request.
// No logic beyond two small helpers used by the controller.
package alu_issue_ctrl_pkg;

    localparam int ADDR_W = 16;

    typedef logic [31:0]       data_t;
    typedef logic [ADDR_W-1:0] instruction_memory_address_t;

    typedef enum logic [3:0] {
        ALU_NOP    = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SLL    = 4'd6,
        ALU_SRL    = 4'd7,
        ALU_MUL    = 4'd8,
        ALU_DIV    = 4'd9,
        ALU_ADDI   = 4'd10,
        ALU_DIVI   = 4'd11,
        ALU_BEQZ   = 4'd12,
        ALU_JAL    = 4'd13,
        ALU_RSVD_E = 4'd14,
        ALU_RSVD_F = 4'd15
    } alu_instruction_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPTURE,
        ST_DONE
    } issue_state_t;

    typedef struct packed {
        alu_instruction_t            instr;
        logic [4:0]                  rd;
        data_t                       op1;
        data_t                       op2;
        data_t                       imm;
        instruction_memory_address_t pc;
    } issue_req_t;

    // Branch target wraps within the instruction address space.
    function automatic instruction_memory_address_t branch_target(
        input instruction_memory_address_t pc,
        input data_t                       imm
    );
        return pc + imm[ADDR_W-1:0];
    endfunction

    function automatic logic is_div_by_zero(
        input alu_instruction_t instr,
        input data_t            op2,
        input data_t            imm
    );
        return ((instr == ALU_DIV) && (op2 == '0)) || ((instr == ALU_DIVI) && (imm == '0));
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one op to an external 1-cycle ALU and formats its completion; optional LOCKIN_DIV_ZERO_GUARD_EN skips the ALU on divide-by-zero.
// Latency: accept -> out_valid in 3 cycles (EXEC, CAPTURE, DONE); one op per 4 cycles at best.
// Backpressure: req_ready only in IDLE; DONE holds all out_* until out_ready.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  alu_instruction_t            req_instr,
    input  logic [4:0]                  req_rd,
    input  logic [31:0]                 req_op1,
    input  logic [31:0]                 req_op2,
    input  logic [31:0]                 req_imm,
    input  instruction_memory_address_t req_pc,

    output logic                        alu_enable,
    output alu_instruction_t            alu_instruction,
    output logic [31:0]                 alu_op1,
    output logic [31:0]                 alu_op2,
    output logic [31:0]                 alu_imm,
    output instruction_memory_address_t alu_pc,
    input  logic [31:0]                 alu_result,
    input  logic                        alu_eq,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_wb_en,
    output logic [4:0]                  out_rd,
    output logic [31:0]                 out_data,
    output logic                        out_br_valid,
    output logic                        out_br_taken,
    output instruction_memory_address_t out_br_target,
    output logic                        busy
);

    issue_state_t                state;
    issue_req_t                  lat;
    logic                        div_zero_skip;
    logic                        skip_alu;
    instruction_memory_address_t pc_inc;

    logic                        nxt_wb_en;
    data_t                       nxt_data;
    logic                        nxt_br_valid;
    logic                        nxt_br_taken;
    instruction_memory_address_t nxt_br_target;

`ifdef LOCKIN_DIV_ZERO_GUARD_EN
    assign skip_alu = is_div_by_zero(req_instr, req_op2, req_imm);
`else
    assign skip_alu = 1'b0;
`endif

    assign alu_instruction = lat.instr;
    assign alu_op1         = lat.op1;
    assign alu_op2         = lat.op2;
    assign alu_imm         = lat.imm;
    assign alu_pc          = lat.pc;

    assign pc_inc = lat.pc + instruction_memory_address_t'(1);

    // Completion fields derived from the latched op and the ALU's CAPTURE-cycle output.
    always_comb begin
        nxt_wb_en     = (lat.instr != ALU_BEQZ) && (lat.rd != 5'd0);
        nxt_data      = alu_result;
        nxt_br_valid  = 1'b0;
        nxt_br_taken  = 1'b0;
        nxt_br_target = '0;
        case (lat.instr)
            ALU_BEQZ: begin
                nxt_br_valid  = 1'b1;
                nxt_br_taken  = alu_eq;
                nxt_br_target = branch_target(lat.pc, lat.imm);
            end
            ALU_JAL: begin
                nxt_br_valid  = 1'b1;
                nxt_br_taken  = 1'b1;
                nxt_br_target = alu_result[ADDR_W-1:0];
                nxt_data      = data_t'(pc_inc);
            end
            default: ;
        endcase
        if (div_zero_skip) begin
            nxt_data = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            alu_enable    <= 1'b0;
            lat           <= '0;
            div_zero_skip <= 1'b0;
            out_valid     <= 1'b0;
            out_wb_en     <= 1'b0;
            out_rd        <= '0;
            out_data      <= '0;
            out_br_valid  <= 1'b0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat           <= '{instr: req_instr, rd: req_rd, op1: req_op1,
                                           op2: req_op2, imm: req_imm, pc: req_pc};
                        div_zero_skip <= skip_alu;
                        alu_enable    <= !skip_alu;
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_enable <= 1'b0;
                    state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_valid     <= 1'b1;
                    out_wb_en     <= nxt_wb_en;
                    out_rd        <= lat.rd;
                    out_data      <= nxt_data;
                    out_br_valid  <= nxt_br_valid;
                    out_br_taken  <= nxt_br_taken;
                    out_br_target <= nxt_br_target;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed literal cases, then randomized traffic against a timing/result model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam data_t DIV0_VAL = 32'h0BAD0BAD;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    alu_instruction_t            req_instr = ALU_NOP;
    logic [4:0]                  req_rd = '0;
    data_t                       req_op1 = '0, req_op2 = '0, req_imm = '0;
    instruction_memory_address_t req_pc = '0;
    logic                        alu_enable;
    alu_instruction_t            alu_instruction;
    data_t                       alu_op1, alu_op2, alu_imm;
    instruction_memory_address_t alu_pc;
    data_t                       alu_result = '0;
    logic                        alu_eq = 1'b0;
    logic                        out_valid;
    logic                        out_ready = 1'b1;
    logic                        out_wb_en;
    logic [4:0]                  out_rd;
    data_t                       out_data;
    logic                        out_br_valid, out_br_taken;
    instruction_memory_address_t out_br_target;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr), .req_rd(req_rd),
        .req_op1(req_op1), .req_op2(req_op2), .req_imm(req_imm), .req_pc(req_pc),
        .alu_enable(alu_enable), .alu_instruction(alu_instruction), .alu_op1(alu_op1),
        .alu_op2(alu_op2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_result(alu_result), .alu_eq(alu_eq),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en), .out_rd(out_rd),
        .out_data(out_data), .out_br_valid(out_br_valid), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target), .busy(busy)
    );

    function automatic data_t alu_fn(input alu_instruction_t ins, input data_t a, input data_t b,
                                     input data_t imm, input instruction_memory_address_t pc);
        case (ins)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_MUL:  return a * b;
            ALU_DIV:  return (b == 0) ? DIV0_VAL : a / b;
            ALU_ADDI: return a + imm;
            ALU_DIVI: return (imm == 0) ? DIV0_VAL : a / imm;
            ALU_JAL:  return data_t'(pc) + imm;
            default:  return '0;
        endcase
    endfunction

    // Registered ALU; garbage when idle so a mistimed capture is visible.
    always @(posedge clk) begin
        if (alu_enable) begin
            alu_result <= alu_fn(alu_instruction, alu_op1, alu_op2, alu_imm, alu_pc);
            alu_eq     <= (alu_instruction == ALU_BEQZ) ? (alu_op1 == 0) : 1'($urandom);
        end else begin
            alu_result <= $urandom;
            alu_eq     <= 1'($urandom);
        end
    end

    typedef struct {
        alu_instruction_t            ins;
        logic [4:0]                  rd;
        data_t                       a, b, imm;
        instruction_memory_address_t pc;
        logic                        skip;
        logic                        wb;
        data_t                       data;
        logic                        brv, brt;
        instruction_memory_address_t tgt;
    } exp_t;

    function automatic exp_t model(input alu_instruction_t ins, input logic [4:0] rd, input data_t a,
                                   input data_t b, input data_t imm, input instruction_memory_address_t pc);
        exp_t e;
        instruction_memory_address_t nxt_pc;
        e.ins = ins; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.pc = pc;
`ifdef LOCKIN_DIV_ZERO_GUARD_EN
        e.skip = (ins == ALU_DIV && b == 0) || (ins == ALU_DIVI && imm == 0);
`else
        e.skip = 1'b0;
`endif
        nxt_pc = pc + 16'd1;
        e.wb   = (ins != ALU_BEQZ) && (rd != 0);
        e.brv  = (ins == ALU_BEQZ) || (ins == ALU_JAL);
        e.brt  = (ins == ALU_JAL) || (a == 0);
        e.tgt  = pc + imm[ADDR_W-1:0];
        e.data = e.skip ? 32'hFFFF_FFFF : (ins == ALU_JAL) ? {16'd0, nxt_pc} : alu_fn(ins, a, b, imm, pc);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: op age in cycles since accept; age 0 = EXEC, 1 = CAPTURE, >=2 = completion offered.
    bit   started = 0;
    bit   inflight = 0;
    int   age = 0;
    exp_t cur;

    always @(posedge clk) begin
        if (reset) begin
            started  = 1;
            inflight = 0;
            age      = 0;
        end else if (started) begin
            if (!inflight) begin
                if (req_valid) begin
                    inflight = 1;
                    age      = 0;
                    cur      = model(req_instr, req_rd, req_op1, req_op2, req_imm, req_pc);
                end
            end else if (age >= 2 && out_ready) begin
                inflight = 0;
            end else begin
                age++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", req_ready, !inflight);
            chk("busy", busy, inflight);
            chk("out_valid", out_valid, inflight && age >= 2);
            chk("alu_enable", alu_enable, inflight && age == 0 && !cur.skip);
            if (inflight && age <= 1) begin
                chk("alu_instruction", alu_instruction, cur.ins);
                chk("alu_op1", alu_op1, cur.a);
                chk("alu_op2", alu_op2, cur.b);
                chk("alu_imm", alu_imm, cur.imm);
                chk("alu_pc", alu_pc, cur.pc);
            end
            if (inflight && age >= 2) begin
                chk("out_wb_en", out_wb_en, cur.wb);
                chk("out_rd", out_rd, cur.rd);
                chk("out_br_valid", out_br_valid, cur.brv);
                if (cur.ins != ALU_BEQZ) chk("out_data", out_data, cur.data);
                if (cur.brv) begin
                    chk("out_br_taken", out_br_taken, cur.brt);
                    chk("out_br_target", out_br_target, cur.tgt);
                end
            end
        end
    end

    typedef struct {
        int                          lat;
        int                          en_cnt;
        logic                        wb;
        logic [4:0]                  rd;
        data_t                       data;
        logic                        brv, brt;
        instruction_memory_address_t tgt;
    } res_t;

    task automatic drive(input alu_instruction_t ins, input logic [4:0] rd, input data_t a,
                         input data_t b, input data_t imm, input instruction_memory_address_t pc);
        req_instr = ins; req_rd = rd; req_op1 = a; req_op2 = b; req_imm = imm; req_pc = pc;
    endtask

    task automatic run_op(input alu_instruction_t ins, input logic [4:0] rd, input data_t a,
                          input data_t b, input data_t imm, input instruction_memory_address_t pc,
                          input int hold, output res_t r);
        int t;
        @(negedge clk);
        drive(ins, rd, a, b, imm, pc);
        req_valid = 1'b1;
        out_ready = (hold == 0);
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_within_bound", t < 50, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        r.lat    = 1;
        r.en_cnt = int'(alu_enable);
        while (!out_valid && r.lat < 50) begin
            @(negedge clk);
            r.lat++;
            r.en_cnt += int'(alu_enable);
        end
        r.wb = out_wb_en; r.rd = out_rd; r.data = out_data;
        r.brv = out_br_valid; r.brt = out_br_taken; r.tgt = out_br_target;
        for (int i = 0; i < hold; i++) begin
            drive(ALU_ADD, 5'd9, 32'd99, 32'd1, 32'd0, 16'h0);
            req_valid = 1'b1;
            @(negedge clk);
            chk("hold_req_ready", req_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_out_data", out_data, r.data);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        res_t r;
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);

        run_op(ALU_ADD, 5'd3, 32'd5, 32'd7, 32'd0, 16'h0, 0, r);
        chk("add_latency", r.lat, 3);
        chk("add_data", r.data, 32'd12);
        chk("add_wb", r.wb, 1'b1);
        chk("add_rd", r.rd, 5'd3);
        chk("add_brv", r.brv, 1'b0);
        chk("add_alu_pulses", r.en_cnt, 1);

        run_op(ALU_BEQZ, 5'd2, 32'd0, 32'd0, 32'd4, 16'h10, 0, r);
        chk("beqz_brv", r.brv, 1'b1);
        chk("beqz_taken", r.brt, 1'b1);
        chk("beqz_target", r.tgt, 16'h14);
        chk("beqz_wb", r.wb, 1'b0);
        run_op(ALU_BEQZ, 5'd2, 32'd9, 32'd0, 32'd4, 16'h10, 0, r);
        chk("beqz_nt_taken", r.brt, 1'b0);

        run_op(ALU_JAL, 5'd1, 32'd0, 32'd0, 32'd8, 16'h20, 0, r);
        chk("jal_target", r.tgt, 16'h28);
        chk("jal_data", r.data, 32'h21);
        chk("jal_wb", r.wb, 1'b1);
        run_op(ALU_JAL, 5'd0, 32'd0, 32'd0, 32'd8, 16'h20, 0, r);
        chk("jal_rd0_wb", r.wb, 1'b0);
        chk("jal_rd0_rd", r.rd, 5'd0);

        run_op(ALU_ADD, 5'd4, 32'd2, 32'd3, 32'd0, 16'h0, 5, r);
        chk("hold_data", r.data, 32'd5);

        // Reset lands on the edge that would have captured MUL 3*4.
        @(negedge clk);
        drive(ALU_MUL, 5'd5, 32'd3, 32'd4, 32'd0, 16'h0);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_alu_enable", alu_enable, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_no_valid", out_valid, 1'b0);
            @(negedge clk);
        end
        run_op(ALU_ADD, 5'd6, 32'd1, 32'd1, 32'd0, 16'h0, 0, r);
        chk("post_rst_add", r.data, 32'd2);

        run_op(ALU_DIVI, 5'd8, 32'd10, 32'd0, 32'd0, 16'h0, 0, r);
`ifdef LOCKIN_DIV_ZERO_GUARD_EN
        chk("divi0_data", r.data, 32'hFFFF_FFFF);
        chk("divi0_alu_pulses", r.en_cnt, 0);
`else
        chk("divi0_data", r.data, DIV0_VAL);
        chk("divi0_alu_pulses", r.en_cnt, 1);
`endif
        chk("divi0_latency", r.lat, 3);

        run_op(ALU_RSVD_E, 5'd7, 32'd11, 32'd22, 32'd33, 16'h5, 0, r);
        chk("unknown_data", r.data, 32'd0);
        chk("unknown_wb", r.wb, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(alu_instruction_t'(4'($urandom_range(0, 15))),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  16'($urandom));
        end
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
